// File: rtl/data_memory_sized_if.sv
// Request/response bus between the MEM stage and the sized data memory.
// The master issues sized loads/stores; the slave answers with a READY pulse.
interface data_memory_sized_if;
    logic        REQ;
    logic        WE;
    logic [1:0]  SIZE;
    logic        UNSIGNED;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        READY;
    logic        ERR;
    logic        BUSY;

    modport master (
        output REQ, WE, SIZE, UNSIGNED, A, WD,
        input  RD, READY, ERR, BUSY
    );

    modport slave (
        input  REQ, WE, SIZE, UNSIGNED, A, WD,
        output RD, READY, ERR, BUSY
    );
endinterface

// File: rtl/data_memory_sized.sv
// Word-organised data RAM with byte/half/word access, load extension,
// configurable wait states and rejection of misaligned/out-of-range requests.
module data_memory_sized #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input logic                CLK,
    input logic                RST,
    data_memory_sized_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ERRS
    } state_e;

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;

    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_uns;
    logic [31:0] acc_a;
    logic [31:0] acc_wd;
    logic        illegal;
    logic        go_resp;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] cur_word;
    logic [31:0] shifted;
    logic [31:0] ld_data;
    logic [3:0]  be;
    logic [31:0] wdat;

    // In IDLE the access is taken straight from the bus so that a
    // zero-wait request can commit on its accepting edge.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we   = bus.WE;
            acc_size = bus.SIZE;
            acc_uns  = bus.UNSIGNED;
            acc_a    = bus.A;
            acc_wd   = bus.WD;
        end else begin
            acc_we   = we_q;
            acc_size = size_q;
            acc_uns  = uns_q;
            acc_a    = a_q;
            acc_wd   = wd_q;
        end
    end

    always_comb begin
        in_range = {2'b00, acc_a[31:2]} < 32'(DEPTH);
        idx      = acc_a[AW+1:2];
        cur_word = in_range ? mem[idx] : '0;
        illegal  = !in_range;
        case (acc_size)
            2'b00:   ;
            2'b01:   if (acc_a[0]) illegal = 1'b1;
            2'b10:   if (acc_a[1:0] != 2'b00) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        be      = 4'hF;
        wdat    = acc_wd;
        shifted = cur_word >> {acc_a[1:0], 3'b000};
        ld_data = cur_word;
        case (acc_size)
            2'b00: begin
                be      = 4'b0001 << acc_a[1:0];
                wdat    = {4{acc_wd[7:0]}};
                ld_data = acc_uns ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be      = acc_a[1] ? 4'b1100 : 4'b0011;
                wdat    = {2{acc_wd[15:0]}};
                ld_data = acc_uns ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        a_d     = a_q;
        wd_d    = wd_q;
        go_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    we_d   = bus.WE;
                    size_d = bus.SIZE;
                    uns_d  = bus.UNSIGNED;
                    a_d    = bus.A;
                    wd_d   = bus.WD;
                    if (illegal) begin
                        state_d = S_ERRS;
                    end else if (WC == 4'd0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WC) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rd_d = (go_resp && !acc_we) ? ld_data : 32'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            a_q     <= 32'h0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    // Reset wins over a pending commit so an abandoned store never lands.
    always_ff @(posedge CLK) begin
        if (!RST && go_resp && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    assign bus.RD    = rd_q;
    assign bus.READY = (state_q == S_RESP) || (state_q == S_ERRS);
    assign bus.ERR   = (state_q == S_ERRS);
    assign bus.BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench: one zero-wait instance (DEPTH=100) and one
// three-wait instance (DEPTH=128) sharing clock and reset.
module tb_data_memory_sized;

    localparam int D0 = 100;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q3[$];

    data_memory_sized_if if0 ();
    data_memory_sized_if if3 ();

    data_memory_sized #(.DEPTH(D0), .WAIT_CYCLES(0)) u0 (
        .CLK(clk), .RST(rst), .bus(if0.slave)
    );
    data_memory_sized #(.DEPTH(128), .WAIT_CYCLES(3)) u3 (
        .CLK(clk), .RST(rst), .bus(if3.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(int d, logic r, logic we, logic [1:0] sz,
                         logic u, logic [31:0] a, logic [31:0] wd);
        if (d == 0) begin
            if0.REQ = r; if0.WE = we; if0.SIZE = sz;
            if0.UNSIGNED = u; if0.A = a; if0.WD = wd;
        end else begin
            if3.REQ = r; if3.WE = we; if3.SIZE = sz;
            if3.UNSIGNED = u; if3.A = a; if3.WD = wd;
        end
    endtask

    task automatic push(int d, logic [31:0] rd, logic err, int due);
        exp_t e;
        e.rd = rd; e.err = err; e.due = due;
        if (d == 0) q0.push_back(e);
        else q3.push_back(e);
    endtask

    // Issue one access; bus inputs are scrambled after acceptance.
    task automatic issue(int d, logic we, logic [1:0] sz, logic u,
                         logic [31:0] a, logic [31:0] wd,
                         logic [31:0] rd_exp, logic err_exp);
        int w;
        w = (d == 0) ? 0 : 3;
        @(negedge clk);
        drive(d, 1'b1, we, sz, u, a, wd);
        push(d, rd_exp, err_exp, cyc + 1 + w);
        @(negedge clk);
        drive(d, 1'b0, ~we, sz, ~u, a ^ 32'h4, ~wd);
        repeat (w) @(negedge clk);
    endtask

    task automatic mon(string nm, ref exp_t q[$], logic [31:0] rd,
                       logic err);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_ready actual=1 required=0", nm);
        end else begin
            e = q.pop_front();
            chk({nm, "_rd"}, rd, e.rd);
            chk({nm, "_err"}, {31'h0, err}, {31'h0, e.err});
            chk({nm, "_latency"}, cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && if0.READY) mon("u0", q0, if0.RD, if0.ERR);
        if (!rst && if3.READY) mon("u3", q3, if3.RD, if3.ERR);
    end

    initial begin
        int k;
        drive(0, 1'b0, 1'b0, SW, 1'b0, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, SW, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_ready0", {31'h0, if0.READY}, 32'h0);
        chk("rst_busy0", {31'h0, if0.BUSY}, 32'h0);
        chk("rst_rd0", if0.RD, 32'h0);
        chk("rst_ready3", {31'h0, if3.READY}, 32'h0);
        chk("rst_err3", {31'h0, if3.ERR}, 32'h0);
        rst = 1'b0;

        issue(0, 1, SW, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 0, SW, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        issue(0, 1, SW, 0, 32'h10, 32'h11223344, 32'h0, 0);
        issue(0, 1, SB, 0, 32'h11, 32'h555555AA, 32'h0, 0);
        issue(0, 0, SB, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0);
        issue(0, 0, SB, 1, 32'h11, 32'h0, 32'h000000AA, 0);
        issue(0, 0, SW, 0, 32'h10, 32'h0, 32'h1122AA44, 0);
        issue(0, 1, SW, 0, 32'h10, 32'h80017FFF, 32'h0, 0);
        issue(0, 0, SH, 0, 32'h12, 32'h0, 32'hFFFF8001, 0);
        issue(0, 0, SH, 1, 32'h12, 32'h0, 32'h00008001, 0);
        issue(0, 0, SH, 0, 32'h10, 32'h0, 32'h00007FFF, 0);
        issue(0, 0, SB, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        issue(0, 0, SH, 0, 32'h13, 32'h0, 32'h0, 1);
        issue(0, 0, SW, 0, 32'h12, 32'h0, 32'h0, 1);
        issue(0, 1, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
        issue(0, 1, SW, 0, 32'h4 * (D0 - 1), 32'hCAFEF00D, 32'h0, 0);
        issue(0, 1, SW, 0, 32'h4 * D0, 32'h12345678, 32'h0, 1);
        issue(0, 0, SW, 0, 32'h4 * (D0 - 1), 32'h0, 32'hCAFEF00D, 0);
        issue(0, 0, SW, 0, 32'h10, 32'h0, 32'h80017FFF, 0);
        issue(0, 1, SW, 0, 32'h14, 32'h0, 32'h0, 0);
        issue(0, 1, SH, 0, 32'h16, 32'h1234BEEF, 32'h0, 0);
        issue(0, 0, SW, 0, 32'h14, 32'h0, 32'hBEEF0000, 0);

        // REQ held for 10 edges: accepts on every other edge.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 5; i++) push(0, 32'h80017FFF, 0, cyc + 1 + 2 * i);
        repeat (10) @(negedge clk);
        drive(0, 1'b0, 1'b0, SW, 1'b0, 32'h0, 32'h0);

        issue(3, 1, SW, 0, 32'h20, 32'h0, 32'h0, 0);
        issue(3, 1, SW, 0, 32'h24, 32'h0BADCAFE, 32'h0, 0);

        // REQ re-asserted while busy must be ignored.
        @(negedge clk);
        drive(3, 1'b1, 1'b0, SW, 1'b0, 32'h24, 32'h0);
        push(3, 32'h0BADCAFE, 0, cyc + 4);
        @(negedge clk);
        chk("busy_w1", {31'h0, if3.BUSY}, 32'h1);
        drive(3, 1'b0, 1'b0, SW, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        chk("busy_w2", {31'h0, if3.BUSY}, 32'h1);
        drive(3, 1'b1, 1'b0, SW, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        chk("busy_w3", {31'h0, if3.BUSY}, 32'h1);
        drive(3, 1'b0, 1'b0, SW, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        chk("busy_resp", {31'h0, if3.BUSY}, 32'h1);
        @(negedge clk);
        chk("busy_idle", {31'h0, if3.BUSY}, 32'h0);
        repeat (6) @(negedge clk);

        // Reset in the second wait cycle abandons the store.
        drive(3, 1'b1, 1'b1, SW, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk);
        drive(3, 1'b0, 1'b1, SW, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk);
        k = cyc;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'h0, if3.BUSY}, 32'h0);
        chk("abort_cycle", cyc, k + 1);
        repeat (6) @(negedge clk);
        issue(3, 0, SW, 0, 32'h20, 32'h0, 32'h0, 0);

        repeat (6) @(negedge clk);
        chk("q0_drained", q0.size(), 32'h0);
        chk("q3_drained", q3.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised next-generation data memory for the processor's MEM stage: word-organised RAM with byte/halfword/word loads and stores and load sign/zero extension.
- Uses a REQ/READY handshake with configurable wait states, so the pipeline can be stall-tested against slow memory.
- Flags misaligned and out-of-range accesses instead of silently aliasing addresses.

Parameters:
- DEPTH, 128, number of 32-bit words; word index = A[31:2]; any positive integer (not necessarily a power of two).
- WAIT_CYCLES, 0, extra cycles between request acceptance and response; range 0..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- REQ  input  1  access request; sampled only in IDLE.
- WE  input  1  1 = store, 0 = load.
- SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0; ignored for word loads and stores.
- A  input  32  byte address.
- WD  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RD  output  32  load result, valid only while READY=1.
- READY  output  1  one-cycle response pulse.
- ERR  output  1  qualifies READY: access was rejected.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RST=1 at an edge):
  - State becomes IDLE; RD=0, READY=0, ERR=0, wait counter=0.
  - Memory contents are unaffected; simulation initial contents are all zero.
  - Reset in WAIT or RESP abandons the access. A store not yet committed is never committed.
- States:
  - IDLE: REQ=1 latches WE, SIZE, UNSIGNED, A, WD. Go to ERRS if the access is illegal; else to WAIT if WAIT_CYCLES>0; else to RESP. REQ=0 stays in IDLE.
  - WAIT: counter counts 1..WAIT_CYCLES; after WAIT_CYCLES cycles go to RESP.
  - RESP: READY=1, ERR=0 for exactly one cycle, then IDLE.
  - ERRS: READY=1, ERR=1, RD=0 for one cycle, then IDLE.
- Illegal access: any of
  - SIZE=11;
  - SIZE=01 with A[0]=1;
  - SIZE=10 with A[1:0]!=00;
  - A[31:2] >= DEPTH.
  Illegal accesses never write memory.
- Latency: READY is high in the cycle exactly WAIT_CYCLES+1 cycles after the accepting edge. Minimum request spacing is WAIT_CYCLES+2 cycles.
- REQ held or re-asserted while BUSY=1 is ignored. A request is accepted only in IDLE, including the cycle immediately after READY.
- Latched inputs are stable for the whole access. Changes on A/WD/WE after acceptance have no effect.
- Store commit: memory word is updated at the edge that enters RESP. Only the addressed lanes change; other bytes keep their values.
  - Byte: lane A[1:0] receives WD[7:0].
  - Half: lanes {A[1],0} and {A[1],1} receive WD[15:0], little-endian.
  - Word: all four lanes receive WD.
  - RD during a store response = 0.
- Load: RD is registered at the edge entering RESP from the current memory word.
  - Byte: lane A[1:0], bit 7 replicated into [31:8] unless UNSIGNED.
  - Half: bit 15 extended unless UNSIGNED.
  - Word: whole word.
- Outside READY cycles, RD holds 0.
- A load issued immediately after a store to the same address returns the stored data, since the store committed before the load was accepted.

Test Plan:
- Reset then word store A=0x10, WD=0xDEADBEEF, WAIT_CYCLES=0; then word load A=0x10 -> READY exactly 1 cycle after each accept, RD=0xDEADBEEF, ERR=0.
- Byte store A=0x11, WD=0x000000AA over word 0x11223344; load byte A=0x11 signed -> RD=0xFFFFFFAA; unsigned -> RD=0x000000AA; word load A=0x10 -> RD=0x1122AA44.
- Halfword load A=0x12 of word 0x80017FFF -> signed RD=0xFFFF8001; halfword A=0x13 -> READY with ERR=1, RD=0. Word store A=0x4*DEPTH -> ERR=1, and the memory is unchanged.
- WAIT_CYCLES=3: REQ pulse with REQ re-asserted while BUSY -> READY 4 cycles after accept, BUSY high 4 cycles, the second REQ is ignored, and exactly one response is produced.
- WAIT_CYCLES=3, store 0x12345678 to A=0x20 with RST pulsed in the second WAIT cycle, then load A=0x20 -> RD=0x00000000; READY does not pulse for the aborted access.
- Back-to-back: REQ held high for 10 cycles with WAIT_CYCLES=0 -> accepts every 2 cycles, giving 5 READY pulses alternating with IDLE accept cycles.
